// File: rtl/spi_slave_gen_if.sv
// SPI slave bus bundle: serial pins, RAM read-data return path and the
// received-frame/status outputs to the RAM controller.
interface spi_slave_gen_if #(
   parameter int DATA_W = 8
);
   localparam int FRAME_W = DATA_W + 2;

   logic               SS_n;
   logic               MOSI;
   logic               MISO;
   logic [DATA_W-1:0]  tx_data;
   logic               tx_valid;
   logic [FRAME_W-1:0] rx_data;
   logic               rx_valid;
   logic               frame_err;
   logic               rd_pending;

   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid, frame_err, rd_pending
   );

   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid, frame_err, rd_pending
   );
endinterface

// File: rtl/spi_slave_gen.sv
// SPI slave for the single-port RAM: 2-bit command + DATA_W payload frames in,
// RAM read data out on MISO, with command checking, abort and read-data timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | SS_n high, waiting for a frame
// CHK_CMD   | sample cmd[1], pick write / read-address / read-data path
// WRITE     | shifting a write frame (cmd 00 or 01)
// READ_ADD  | shifting a read-address frame (cmd 10)
// READ_DATA | shifting a read-data frame (cmd 11)
// WAIT_TX   | waiting up to TX_TIMEOUT cycles for tx_valid
// SEND      | serialising latched tx_data on MISO, MSB first
// DONE      | frame complete, ignoring MOSI until SS_n rises
module spi_slave_gen #(
   parameter int DATA_W     = 8,
   parameter int TX_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_slave_gen_if.slave  bus
);
   localparam int FRAME_W = DATA_W + 2;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int WAIT_W  = $clog2(TX_TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0]  SEND_BITS = CNT_W'(DATA_W);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [FRAME_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
   logic [FRAME_W-1:0] rx_data_q, rx_data_d;
   logic               miso_q, miso_d;
   logic               rx_valid_q, rx_valid_d;
   logic               frame_err_q, frame_err_d;
   logic               rd_pending_q, rd_pending_d;
   logic [FRAME_W-1:0] frame;
   logic [1:0]         cmd;
   logic               cmd_ok;
   logic               shifting;

   assign frame = {shift_q[FRAME_W-2:0], bus.MOSI};
   assign cmd   = frame[FRAME_W-1:FRAME_W-2];
   assign shifting = (state_q == CHK_CMD) || (state_q == WRITE) ||
                     (state_q == READ_ADD) || (state_q == READ_DATA);

   always_comb begin
      cmd_ok = 1'b0;
      case (state_q)
         WRITE:     cmd_ok = (cmd[1] == 1'b0);
         READ_ADD:  cmd_ok = (cmd == 2'b10);
         READ_DATA: cmd_ok = (cmd == 2'b11);
         default:   cmd_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      shift_d      = shift_q;
      tx_shift_d   = tx_shift_q;
      rx_data_d    = rx_data_q;
      miso_d       = 1'b0;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      rd_pending_d = rd_pending_q;

      // SS_n release outranks everything, including the last-bit edge
      if (state_q != IDLE && bus.SS_n) begin
         state_d     = IDLE;
         bit_cnt_d   = '0;
         wait_cnt_d  = '0;
         frame_err_d = shifting;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus.SS_n) begin
                  state_d   = CHK_CMD;
                  bit_cnt_d = '0;
               end
            end
            CHK_CMD: begin
               shift_d   = frame;
               bit_cnt_d = CNT_W'(1);
               if (!bus.MOSI)         state_d = WRITE;
               else if (rd_pending_q) state_d = READ_DATA;
               else                   state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               shift_d = frame;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = DONE;
                  if (cmd_ok) begin
                     rx_data_d  = frame;
                     rx_valid_d = 1'b1;
                     if (state_q == READ_ADD) rd_pending_d = 1'b1;
                     if (state_q == READ_DATA) begin
                        state_d    = WAIT_TX;
                        wait_cnt_d = '0;
                     end
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            WAIT_TX: begin
               if (bus.tx_valid) begin
                  tx_shift_d = bus.tx_data << 1;
                  miso_d     = bus.tx_data[DATA_W-1];
                  bit_cnt_d  = CNT_W'(1);
                  wait_cnt_d = '0;
                  state_d    = SEND;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  // rd_pending stays set so the master can retry the read
                  frame_err_d = 1'b1;
                  wait_cnt_d  = '0;
                  state_d     = DONE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            SEND: begin
               if (bit_cnt_q == SEND_BITS) begin
                  rd_pending_d = 1'b0;
                  bit_cnt_d    = '0;
                  state_d      = DONE;
               end else begin
                  miso_d     = tx_shift_q[DATA_W-1];
                  tx_shift_d = tx_shift_q << 1;
                  bit_cnt_d  = bit_cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         wait_cnt_q   <= '0;
         shift_q      <= '0;
         tx_shift_q   <= '0;
         rx_data_q    <= '0;
         miso_q       <= 1'b0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         rd_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         shift_q      <= shift_d;
         tx_shift_q   <= tx_shift_d;
         rx_data_q    <= rx_data_d;
         miso_q       <= miso_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         rd_pending_q <= rd_pending_d;
      end
   end

   assign bus.MISO       = miso_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.rd_pending = rd_pending_q;
endmodule

// File: doc/spi_slave_gen.md
Name: spi_slave_gen

Overview:
Parametrised SPI slave for the single-port RAM subsystem, generalising the existing 10-bit SPI slave to a DATA_W-bit payload with a 2-bit command header. It deserialises MOSI frames into rx_data/rx_valid for the RAM controller and serialises RAM read data (tx_data/tx_valid) back on MISO. Compared with the existing slave it adds:
- command-consistency checking
- frame-abort detection
- a bounded wait for read data
- an exported read-pending flag
The bit clock is the system clock clk, and MOSI is sampled on every rising edge while SS_n is low.

Parameters:
DATA_W, 8, payload width. FRAME_W = DATA_W+2 (2-bit command + payload).
TX_TIMEOUT, 16, maximum clk cycles to wait for tx_valid after a read-data frame (>=1).

Ports:
clk  input  1  system clock, also the SPI bit clock
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low; frame framing
MOSI  input  1  serial data in, MSB (command bit 1) first
tx_data  input  DATA_W  RAM read data to return
tx_valid  input  1  tx_data valid; sampled only in WAIT_TX
MISO  output  1  serial data out, MSB first
rx_data  output  FRAME_W  received frame {cmd[1:0], payload}
rx_valid  output  1  one-cycle pulse, rx_data holds a new good frame
frame_err  output  1  one-cycle pulse, frame aborted, bad command or tx timeout
rd_pending  output  1  read address accepted, read-data frame expected

Behaviour:
Reset (asynchronous, rst_n=0):
- state=IDLE, all outputs 0, counters 0, internal shift and tx registers 0.

Timing and interface rules:
- All outputs are registered.
- Counter width is $clog2(FRAME_W+1) bits.

States and transitions:
- IDLE: SS_n=0 -> CHK_CMD.
- CHK_CMD (one cycle): samples MOSI as cmd[1] and shifts it in (bit count = 1).
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_pending=0 -> READ_ADD.
  - MOSI=1 and rd_pending=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift MOSI in each cycle. On the edge sampling bit FRAME_W, form frame = {shift[FRAME_W-2:0], MOSI}, then check cmd = frame[FRAME_W-1:FRAME_W-2].
  - Expected command per state: WRITE 00 or 01; READ_ADD 10; READ_DATA 11.
  - Match: rx_data<=frame, rx_valid=1 for the next cycle.
  - Mismatch: rx_data unchanged, frame_err=1 for one cycle.
  - Next state after the last bit: WRITE -> DONE; READ_ADD -> DONE, and rd_pending<=1 only if the command matched; READ_DATA -> WAIT_TX if matched, else DONE.
- WAIT_TX: a wait counter counts cycles.
  - tx_valid=1: latch tx_data, MISO<=tx_data[DATA_W-1] on the same edge, go to SEND.
  - Wait counter reaches TX_TIMEOUT with no tx_valid: frame_err pulse, go to DONE, rd_pending stays 1 so the master can retry.
- SEND: MISO presents the remaining bits MSB first, one per cycle, DATA_W bits total.
  - After the LSB has been driven for one cycle: MISO<=0, rd_pending<=0, go to DONE.
- DONE: MISO=0, extra MOSI bits are ignored. SS_n=1 -> IDLE.

SS_n=1 in any state other than IDLE:
- Next state is IDLE; MISO<=0; bit and wait counters cleared.
- Before the FRAME_W-th bit has been sampled: frame_err pulse, no rx_valid, rd_pending unchanged.
- In WAIT_TX or SEND: no frame_err, rd_pending unchanged.

Simultaneous events:
- SS_n rising on the same edge that samples bit FRAME_W: bit sampling is gated by SS_n=0, so this is treated as an abort.

Output rules:
- MISO is 0 whenever state is not SEND.
- rx_valid and frame_err are never high in the same cycle.
- rx_data holds its value between frames.

Test Plan:
1. DATA_W=8; SS_n low, MOSI 00_1010_0101, SS_n high -> rx_data=0x0A5; rx_valid high exactly one cycle, 11 cycles after the SS_n-low edge; frame_err stays 0.
2. Read address frame 10_0011_1100 -> rx_data=0x23C, rx_valid pulse, rd_pending=1. Then frame 11_xxxx_xxxx; RAM model drives tx_valid with tx_data=0xB6 two cycles after rx_valid -> MISO serialises 1,0,1,1,0,1,1,0 on consecutive cycles, then rd_pending=0.
3. Read-data frame with tx_valid held 0 -> frame_err pulse exactly TX_TIMEOUT=16 cycles after entering WAIT_TX; MISO stays 0; rd_pending stays 1.
4. SS_n raised after 6 of 10 bits of a write frame -> frame_err pulse, no rx_valid, rx_data retains its prior value. The next full frame 01_1111_0000 -> rx_data=0x1F0.
5. With rd_pending=1, send frame 10_0000_0001 (command mismatch in READ_DATA) -> frame_err, no rx_valid, MISO stays 0.
6. Assert rst_n=0 asynchronously mid-SEND -> MISO, rx_valid and rd_pending drop to 0 immediately without waiting for a clock edge; state is IDLE after release.
